rgmii_rx_framer: RTL and testbench
==================================

RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 The block SHALL have parameter max_frame_bytes_p, default 1522, giving the maximum post-SFD byte count accepted per frame (range 64..2047).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single RX clock.
REQ-003 The block SHALL have port reset_n_i, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port rxd_rise_i, input, 4 bits: RXD nibble captured on the rising edge (delayed RGMII data after DDR capture).
REQ-005 The block SHALL have port rxd_fall_i, input, 4 bits: RXD nibble captured on the falling edge, aligned to the same clk_i cycle.
REQ-006 The block SHALL have ports rx_ctl_rise_i and rx_ctl_fall_i, input, 1 bit each: RX_CTL sampled on the rising and falling edges.
REQ-007 The block SHALL have port data_o, output, 8 bits: received frame byte.
REQ-008 The block SHALL have port valid_o, output, 1 bit: data_o valid this cycle. There is no backpressure.
REQ-009 The block SHALL have port last_o, output, 1 bit: qualifies the final byte of a frame.
REQ-010 The block SHALL have port error_o, output, 1 bit: valid with last_o; the frame is bad.
REQ-011 The block SHALL have ports link_up_o (1 bit), speed_o (2 bits) and full_duplex_o (1 bit), all outputs, carrying the in-band PHY status.

Function
REQ-012 Per cycle, the block SHALL form the byte as {rxd_fall_i, rxd_rise_i}, set dv = rx_ctl_rise_i and set er = rx_ctl_rise_i XOR rx_ctl_fall_i.
REQ-013 The FSM SHALL use the states IDLE, PREAMBLE, DATA and DROP.
REQ-014 IDLE SHALL transition as follows: dv=1 and byte=0x55 and er=0 -> PREAMBLE; dv=1 with any other byte or er=1 -> DROP; dv=0 -> stay in IDLE.
REQ-015 PREAMBLE SHALL transition as follows: 0x55 -> stay; 0xD5 -> DATA; dv=0 -> IDLE with no output; other byte or er=1 -> DROP.
REQ-016 In DATA, each dv=1 byte SHALL be written into a one-byte hold register; the previously held byte SHALL be emitted with valid_o=1 and last_o=0.
REQ-017 In DATA, when dv=0 the held byte SHALL be emitted with last_o=1, and the FSM SHALL go to IDLE.
REQ-018 The total latency from input byte to data_o SHALL be 2 cycles: one input register plus the hold register.
REQ-019 An er=1 cycle while in DATA SHALL set a sticky error flag; that byte SHALL still be counted and emitted, and error_o SHALL equal the flag on the last_o byte. The flag SHALL clear on entry to DATA.
REQ-020 Oversize frames SHALL be truncated as follows:
- An 11-bit byte counter SHALL count bytes from the SFD.
- When a byte would make the count exceed max_frame_bytes_p, the held byte SHALL be emitted with last_o=1 and error_o=1.
- The FSM SHALL then enter DROP.
- The counter SHALL saturate and never wrap.
REQ-021 DROP SHALL discard all input while dv=1 and SHALL go to IDLE on the first dv=0 cycle.
REQ-022 A frame consisting of an SFD followed immediately by dv=0 SHALL produce no output beat.
REQ-023 A frame of exactly one byte SHALL produce a single beat with valid_o=1 and last_o=1.
REQ-024 A back-to-back frame SHALL be accepted: the last_o of frame A and an IDLE->PREAMBLE transition for frame B may occur in the same cycle.
REQ-025 valid_o, last_o and error_o SHALL be 0 whenever the block is not emitting a beat; data_o is don't-care when valid_o=0.

Reset
REQ-026 While reset_n_i=0 at a clk_i edge, the block SHALL set FSM=IDLE, the hold register empty, valid_o=0, last_o=0, error_o=0, data_o=0x00, the counter to 0, link_up_o=0, speed_o=2'b00 and full_duplex_o=0.
REQ-027 A reset asserted mid-frame SHALL abort that frame with no last_o. The frame's remaining dv=1 bytes after reset release SHALL be handled per REQ-014 (DROP).

Configuration
REQ-028 Macro RGMII_RX_INBAND_STATUS_EN SHALL control in-band status decoding.
- Defined: in IDLE with dv=0 and er=0, and rxd_rise_i equal to rxd_fall_i, the block SHALL register link_up_o=rxd[0], speed_o=rxd[2:1] and full_duplex_o=rxd[3] with 1-cycle latency. Otherwise these outputs SHALL hold.
- Undefined: these outputs SHALL be tied to 0 and the decode logic SHALL be absent.

Verification
REQ-029 7x0x55, 0xD5, bytes 0x01..0x40, then dv=0 -> 64 beats 0x01..0x40, last_o on 0x40, error_o=0, first beat 2 cycles after 0x01.
REQ-030 Same frame with er=1 on byte 10 -> 64 beats, last_o beat has error_o=1; a following clean frame has error_o=0.
REQ-031 max_frame_bytes_p=64 and a 100-byte payload -> exactly 64 beats, last_o=1 and error_o=1 on beat 64, nothing further until after dv=0.
REQ-032 0x55, 0x55, 0xAA (bad SFD) then payload -> no beats; the next valid frame is received intact.
REQ-033 Reset pulsed during byte 20 of a frame -> outputs 0 immediately, no last_o, remaining bytes dropped, the next frame is correct.
REQ-034 With RGMII_RX_INBAND_STATUS_EN and idle nibbles 0xD/0xD -> link_up_o=1, speed_o=2'b10, full_duplex_o=1; with idle nibbles 0xD/0x5 -> no change.

Source files
------------

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: DDR nibbles -> byte stream with last/error.
// Optional in-band PHY status decode enabled by RGMII_RX_INBAND_STATUS_EN.
module rgmii_rx_framer #(
    parameter int unsigned max_frame_bytes_p = 1522
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [3:0] rxd_rise_i,
    input  logic [3:0] rxd_fall_i,
    input  logic       rx_ctl_rise_i,
    input  logic       rx_ctl_fall_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       last_o,
    output logic       error_o,
    output logic       link_up_o,
    output logic [1:0] speed_o,
    output logic       full_duplex_o
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_e;

    localparam logic [10:0] MaxBytes = 11'(max_frame_bytes_p);
    localparam logic [10:0] CntSat  = 11'h7FF;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        err_q, err_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_vld_q, out_vld_d;
    logic        out_last_q, out_last_d;
    logic        out_err_q, out_err_d;

    logic [7:0]  byte_w;
    logic        dv_w;
    logic        er_w;
    logic        at_limit_w;
    logic [10:0] cnt_inc_w;

    assign byte_w     = {rxd_fall_i, rxd_rise_i};
    assign dv_w       = rx_ctl_rise_i;
    assign er_w       = rx_ctl_rise_i ^ rx_ctl_fall_i;
    assign at_limit_w = (cnt_q >= MaxBytes);
    assign cnt_inc_w  = (cnt_q == CntSat) ? cnt_q : cnt_q + 11'd1;

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from the current DDR sample
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dv_w) begin
                    if (byte_w == 8'h55 && !er_w) begin
                        state_d = PREAMBLE;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_w) begin
                    state_d = IDLE;
                end else if (er_w) begin
                    state_d = DROP;
                end else if (byte_w == 8'h55) begin
                    state_d = PREAMBLE;
                end else if (byte_w == 8'hD5) begin
                    state_d = DATA;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!dv_w) begin
                    state_d = IDLE;
                end else if (at_limit_w) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!dv_w) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Hold register, byte counter, sticky error and beat generation
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
        out_err_d  = 1'b0;
        unique case (state_q)
            PREAMBLE: begin
                if (dv_w && !er_w && byte_w == 8'hD5) begin
                    hold_vld_d = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                end
            end
            DATA: begin
                if (!dv_w) begin
                    // End of frame: flush the held byte as the last beat
                    out_vld_d  = hold_vld_q;
                    out_last_d = hold_vld_q;
                    out_err_d  = hold_vld_q & err_q;
                    out_data_d = hold_q;
                    hold_vld_d = 1'b0;
                end else if (at_limit_w) begin
                    // Oversize: close the frame on the held byte as bad
                    out_vld_d  = hold_vld_q;
                    out_last_d = hold_vld_q;
                    out_err_d  = hold_vld_q;
                    out_data_d = hold_q;
                    hold_vld_d = 1'b0;
                    cnt_d      = cnt_inc_w;
                end else begin
                    out_vld_d  = hold_vld_q;
                    out_data_d = hold_q;
                    hold_d     = byte_w;
                    hold_vld_d = 1'b1;
                    cnt_d      = cnt_inc_w;
                    err_d      = err_q | er_w;
                end
            end
            default: begin
                hold_vld_d = hold_vld_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_err_q  <= out_err_d;
        end
    end

    assign data_o  = out_data_q;
    assign valid_o = out_vld_q;
    assign last_o  = out_last_q;
    assign error_o = out_err_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
    logic       link_q;
    logic [1:0] speed_q;
    logic       dup_q;
    logic       status_upd_w;

    assign status_upd_w = (state_q == IDLE) && !dv_w && !er_w &&
                          (rxd_rise_i == rxd_fall_i);

    // Capture in-band PHY status from inter-frame idle nibbles
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            link_q  <= 1'b0;
            speed_q <= 2'b00;
            dup_q   <= 1'b0;
        end else if (status_upd_w) begin
            link_q  <= rxd_rise_i[0];
            speed_q <= rxd_rise_i[2:1];
            dup_q   <= rxd_rise_i[3];
        end
    end

    assign link_up_o     = link_q;
    assign speed_o       = speed_q;
    assign full_duplex_o = dup_q;
`else
    assign link_up_o     = 1'b0;
    assign speed_o       = 2'b00;
    assign full_duplex_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed scoreboard bench for rgmii_rx_framer (max_frame_bytes_p=64).
module tb_rgmii_rx_framer;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic [3:0] rxd_rise_i;
    logic [3:0] rxd_fall_i;
    logic       rx_ctl_rise_i;
    logic       rx_ctl_fall_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       last_o;
    logic       error_o;
    logic       link_up_o;
    logic [1:0] speed_o;
    logic       full_duplex_o;

    localparam int MaxB = 64;

    always #5 clk = ~clk;

    rgmii_rx_framer #(.max_frame_bytes_p(MaxB)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .rxd_rise_i    (rxd_rise_i),
        .rxd_fall_i    (rxd_fall_i),
        .rx_ctl_rise_i (rx_ctl_rise_i),
        .rx_ctl_fall_i (rx_ctl_fall_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .error_o       (error_o),
        .link_up_o     (link_up_o),
        .speed_o       (speed_o),
        .full_duplex_o (full_duplex_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       e;
    } beat_t;

    beat_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_cyc = -1;
    bit armed    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        beat_t b;
        if (valid_o === 1'b1) begin
            if (armed) begin
                first_cyc = cyc;
                armed = 1'b0;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {24'h0, data_o}, 32'hFFFF_FFFF);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", {24'h0, data_o}, {24'h0, b.d});
                chk("beat_last", {31'h0, last_o}, {31'h0, b.l});
                chk("beat_err", {31'h0, error_o}, {31'h0, b.e});
            end
        end else begin
            chk("idle_flags", {30'h0, last_o, error_o}, 32'h0);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic dv,
                        input logic er);
        rxd_rise_i    = b[3:0];
        rxd_fall_i    = b[7:4];
        rx_ctl_rise_i = dv;
        rx_ctl_fall_i = dv ^ er;
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int n, input int er_at, input int gap,
                              output int drv_cyc);
        int nb;
        bit bad;
        beat_t b;
        nb  = (n > MaxB) ? MaxB : n;
        bad = (n > MaxB) || (er_at >= 1 && er_at <= nb);
        drv_cyc = -1;
        preamble();
        for (int i = 1; i <= n; i++) begin
            if (i <= nb) begin
                b.d = 8'(i);
                b.l = (i == nb);
                b.e = (i == nb) && bad;
                exp_q.push_back(b);
            end
            if (i == 1) drv_cyc = cyc;
            step(8'(i), 1'b1, (i == er_at));
        end
        for (int g = 0; g < gap; g++) step(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int dc;
        beat_t b;
        reset_n_i = 1'b0;
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_data", {24'h0, data_o}, 32'h0);
        chk("rst_lasterr", {30'h0, last_o, error_o}, 32'h0);
        chk("rst_status", {28'h0, link_up_o, speed_o, full_duplex_o}, 32'h0);
        reset_n_i = 1'b1;
        step(8'h00, 1'b0, 1'b0);

        step(8'hDD, 1'b0, 1'b0);
`ifdef RGMII_RX_INBAND_STATUS_EN
        chk("ib_set", {28'h0, link_up_o, speed_o, full_duplex_o}, 32'hD);
        step(8'h5D, 1'b0, 1'b0);
        chk("ib_hold", {28'h0, link_up_o, speed_o, full_duplex_o}, 32'hD);
`else
        chk("ib_off", {28'h0, link_up_o, speed_o, full_duplex_o}, 32'h0);
        step(8'h5D, 1'b0, 1'b0);
        chk("ib_off2", {28'h0, link_up_o, speed_o, full_duplex_o}, 32'h0);
`endif
        step(8'h00, 1'b0, 1'b0);

        armed = 1'b1;
        send_frame(64, 0, 3, dc);
        chk("latency", 32'(first_cyc - dc), 32'd2);

        send_frame(64, 10, 3, dc);
        send_frame(64, 0, 3, dc);

        send_frame(100, 0, 4, dc);

        step(8'h55, 1'b1, 1'b0);
        step(8'h55, 1'b1, 1'b0);
        step(8'hAA, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) step(8'(i), 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        send_frame(20, 0, 3, dc);

        preamble();
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        send_frame(1, 0, 3, dc);

        send_frame(5, 0, 1, dc);
        send_frame(6, 0, 3, dc);

        preamble();
        for (int i = 1; i <= 19; i++) begin
            if (i <= 18) begin
                b.d = 8'(i);
                b.l = 1'b0;
                b.e = 1'b0;
                exp_q.push_back(b);
            end
            step(8'(i), 1'b1, 1'b0);
        end
        reset_n_i = 1'b0;
        step(8'd20, 1'b1, 1'b0);
        reset_n_i = 1'b1;
        chk("midrst_valid", {31'h0, valid_o}, 32'h0);
        chk("midrst_last", {31'h0, last_o}, 32'h0);
        chk("midrst_data", {24'h0, data_o}, 32'h0);
        for (int i = 21; i <= 40; i++) step(8'(i), 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) step(8'h00, 1'b0, 1'b0);
        send_frame(10, 0, 3, dc);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
